// File: rtl/addsub_datapath.sv
// Two-stage 7-bit add/subtract pipeline with a batch accumulator and done pulse.
// Optional unsigned saturation of result when ADDSUB_DATAPATH_SAT_EN is defined.
module addsub_datapath #(
    parameter int unsigned BATCH_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] A,
    input  logic [6:0] B,
    input  logic       OP,
    input  logic       in_valid,
    input  logic       clr,
    output logic [6:0] result,
    output logic       carry,
    output logic       ovf,
    output logic       zero,
    output logic       out_valid,
    output logic [9:0] acc,
    output logic [3:0] op_count,
    output logic       ovf_seen,
    output logic       done
);

    typedef enum logic {COUNTING, COMPLETE} state_t;

    state_t     state, state_nxt;
    logic [6:0] a1, b1;
    logic       op1, v1;
    logic [7:0] sum8, diff8;
    logic [6:0] raw, res_c;
    logic       carry_c, ovf_c;
    logic       count_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            op1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                a1  <= A;
                b1  <= B;
                op1 <= OP;
            end
        end
    end

    always_comb begin
        sum8    = {1'b0, a1} + {1'b0, b1};
        diff8   = {1'b0, a1} - {1'b0, b1};
        raw     = sum8[6:0];
        carry_c = sum8[7];
        ovf_c   = (a1[6] == b1[6]) && (sum8[6] != a1[6]);
        if (op1) begin
            raw     = diff8[6:0];
            carry_c = diff8[7];
            ovf_c   = (a1[6] != b1[6]) && (diff8[6] != a1[6]);
        end
        res_c = raw;
`ifdef ADDSUB_DATAPATH_SAT_EN
        // carry/ovf keep describing the unsaturated operation
        if (carry_c) res_c = op1 ? '0 : '1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                result <= res_c;
                carry  <= carry_c;
                ovf    <= ovf_c;
                zero   <= (res_c == '0);
            end
        end
    end

    assign count_hit = (op_count == 4'(BATCH_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc      <= '0;
            op_count <= '0;
            ovf_seen <= 1'b0;
        end else if (out_valid) begin
            acc      <= acc + {3'b0, result};
            ovf_seen <= ovf_seen | ovf;
            op_count <= count_hit ? '0 : op_count + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= COUNTING;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = COUNTING;
        if (out_valid && !clr && count_hit) state_nxt = COMPLETE;
    end

    assign done = (state == COMPLETE);

endmodule

// File: tb/tb_addsub_datapath.sv
// Directed, table-driven bench for addsub_datapath (default build, BATCH_LEN=3).
module tb_addsub_datapath;

    localparam int unsigned BL = 3;

    logic       clk = 1'b0;
    logic       reset, in_valid, clr, OP;
    logic [6:0] A, B;
    logic [6:0] result;
    logic       carry, ovf, zero, out_valid, ovf_seen, done;
    logic [9:0] acc;
    logic [3:0] op_count;

    int n_cmp = 0;
    int n_fail = 0;

    addsub_datapath #(.BATCH_LEN(BL)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .OP(OP), .in_valid(in_valid),
        .clr(clr), .result(result), .carry(carry), .ovf(ovf), .zero(zero),
        .out_valid(out_valid), .acc(acc), .op_count(op_count),
        .ovf_seen(ovf_seen), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] a, b;
        logic       op;
        logic [6:0] r;
        logic       c, v, z;
    } vec_t;

    localparam int NV = 9;
    vec_t vt[NV];

    logic [9:0] acc_m;
    logic [3:0] cnt_m;
    logic       ovf_m, done_m;
    logic [6:0] last_r;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] a, input logic [6:0] b, input logic op);
        A = a; B = b; OP = op; in_valid = 1'b1;
    endtask

    initial begin
        vt[0] = '{7'd72,  7'd122, 1'b0, 7'd66,  1'b1, 1'b0, 1'b0};
        vt[1] = '{7'd57,  7'd6,   1'b0, 7'd63,  1'b0, 1'b0, 1'b0};
        vt[2] = '{7'd2,   7'd2,   1'b1, 7'd0,   1'b0, 1'b0, 1'b1};
        vt[3] = '{7'd63,  7'd1,   1'b0, 7'd64,  1'b0, 1'b1, 1'b0};
        vt[4] = '{7'd5,   7'd9,   1'b1, 7'd124, 1'b1, 1'b0, 1'b0};
        vt[5] = '{7'd64,  7'd1,   1'b1, 7'd63,  1'b0, 1'b1, 1'b0};
        vt[6] = '{7'd127, 7'd1,   1'b0, 7'd0,   1'b1, 1'b0, 1'b1};
        vt[7] = '{7'd0,   7'd127, 1'b1, 7'd1,   1'b1, 1'b0, 1'b0};
        vt[8] = '{7'd100, 7'd30,  1'b0, 7'd2,   1'b1, 1'b0, 1'b0};

        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; A = '0; B = '0; OP = 1'b0;
        @(negedge clk);
        tick; tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_acc", acc, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf_seen", ovf_seen, 0);
        reset = 1'b0;
        tick;

        acc_m = '0; cnt_m = '0; ovf_m = 1'b0;
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].a, vt[i].b, vt[i].op);
            tick;
            in_valid = 1'b0;
            chk("lat_not_early", out_valid, 0);
            tick;
            chk("vec_out_valid", out_valid, 1);
            chk("vec_result", result, vt[i].r);
            chk("vec_carry", carry, vt[i].c);
            chk("vec_ovf", ovf, vt[i].v);
            chk("vec_zero", zero, vt[i].z);
            acc_m = acc_m + {3'b0, vt[i].r};
            ovf_m = ovf_m | vt[i].v;
            if (cnt_m == 4'(BL - 1)) begin cnt_m = '0; done_m = 1'b1; end
            else begin cnt_m = cnt_m + 4'd1; done_m = 1'b0; end
            tick;
            chk("vec_acc", acc, acc_m);
            chk("vec_op_count", op_count, cnt_m);
            chk("vec_ovf_seen", ovf_seen, ovf_m);
            chk("vec_done", done, done_m);
            chk("vec_valid_drop", out_valid, 0);
            chk("vec_result_hold", result, vt[i].r);
        end

        // Bring op_count to 2, then clear on the cycle that would complete the batch
        for (int i = 0; i < 2; i++) begin
            drive(7'd1, 7'd1, 1'b0);
            tick; in_valid = 1'b0; tick; tick;
        end
        chk("pre_clr_count", op_count, 2);
        chk("pre_clr_acc", acc, acc_m + 10'd4);
        drive(7'd10, 7'd20, 1'b0);
        tick; in_valid = 1'b0; tick;
        chk("clr_result", result, 30);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        chk("clr_acc", acc, 0);
        chk("clr_op_count", op_count, 0);
        chk("clr_ovf_seen", ovf_seen, 0);
        chk("clr_no_done", done, 0);
        drive(7'd3, 7'd4, 1'b0);
        tick; in_valid = 1'b0; tick; tick;
        chk("post_clr_acc", acc, 7);
        chk("post_clr_count", op_count, 1);

        reset = 1'b1; tick; reset = 1'b0;

        // Back-to-back stream
        drive(7'd72, 7'd122, 1'b0); tick;
        drive(7'd57, 7'd6, 1'b0);   tick;
        chk("b2b_r0", result, 66);
        chk("b2b_v0", out_valid, 1);
        drive(7'd2, 7'd2, 1'b1);    tick;
        in_valid = 1'b0;
        chk("b2b_r1", result, 63);
        chk("b2b_cnt1", op_count, 1);
        tick;
        chk("b2b_r2", result, 0);
        chk("b2b_z2", zero, 1);
        chk("b2b_cnt2", op_count, 2);
        chk("b2b_done_early", done, 0);
        tick;
        chk("b2b_cnt0", op_count, 0);
        chk("b2b_done", done, 1);
        chk("b2b_acc", acc, 129);
        tick;
        chk("b2b_done_pulse", done, 0);
        chk("b2b_acc_keep", acc, 129);

        // Reset with operations in flight; the op presented during reset is dropped
        drive(7'd5, 7'd9, 1'b1); tick;
        drive(7'd63, 7'd1, 1'b0); reset = 1'b1; tick;
        reset = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("flush_out_valid", out_valid, 0);
            tick;
        end
        chk("flush_result", result, 0);
        chk("flush_carry", carry, 0);
        chk("flush_ovf", ovf, 0);
        chk("flush_acc", acc, 0);
        chk("flush_op_count", op_count, 0);
        chk("flush_ovf_seen", ovf_seen, 0);
        chk("flush_done", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_datapath.md
ADDSUB_DATAPATH -- requirements
Module: addsub_datapath

Interface
REQ-001 Parameter BATCH_LEN, default 3, is the number of accepted operations per batch before done pulses; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 A  input  7  operand A from the upstream controller.
REQ-005 B  input  7  operand B from the upstream controller.
REQ-006 OP  input  1  0 = A+B, 1 = A-B.
REQ-007 in_valid  input  1  A/B/OP are qualified this cycle.
REQ-008 clr  input  1  synchronous clear of acc, op_count, ovf_seen.
REQ-009 result  output  7  arithmetic result.
REQ-010 carry  output  1  carry-out (add) or borrow (sub).
REQ-011 ovf  output  1  two's-complement signed overflow of the 7-bit operation.
REQ-012 zero  output  1  result == 0.
REQ-013 out_valid  output  1  result/flags qualified this cycle.
REQ-014 acc  output  10  running sum of results, modulo 1024.
REQ-015 op_count  output  4  results produced in current batch.
REQ-016 ovf_seen  output  1  sticky: some result since last clear had ovf=1.
REQ-017 done  output  1  one-cycle pulse when a batch completes.

Function
REQ-018 Stage 1 SHALL capture A, B, OP into operand registers and set v1=1 on any cycle with in_valid=1; v1=0 otherwise.
REQ-019 Stage 2 SHALL compute from stage-1 registers and register result, carry, ovf, zero, out_valid=v1; latency in_valid -> out_valid exactly 2 cycles, throughput one op per cycle.
REQ-020 Add: {carry,result} = A+B (8-bit); Sub: result = (A-B) mod 128, carry = 1 iff A<B unsigned.
REQ-021 ovf: add -> operands same sign, result sign differs; sub -> operand signs differ, result sign differs from A.
REQ-022 result, carry, ovf, zero SHALL hold their last values while out_valid=0.
REQ-023 On out_valid=1: acc <= acc + {3'b0,result} wrapping 1023->0; ovf_seen <= ovf_seen | ovf; op_count increments.
REQ-024 Batch FSM states COUNTING and COMPLETE: when op_count would reach BATCH_LEN, op_count <= 0 and done=1 for that following cycle (COMPLETE, one cycle), then back to COUNTING; acc is not cleared by batch completion.
REQ-025 clr=1 SHALL force acc=0, op_count=0, ovf_seen=0 next cycle, overriding a simultaneous out_valid update (that result is not accumulated, no done); pipeline contents unaffected.
REQ-026 in_valid gaps SHALL not disturb in-flight operations; back-to-back and gapped streams yield identical results.

Reset
REQ-027 reset=1 SHALL clear v1, out_valid, result, carry, ovf, zero, acc, op_count, ovf_seen, done to 0 and FSM to COUNTING on the next edge, discarding in-flight operations.
REQ-028 reset SHALL take priority over in_valid and clr; an in_valid in the reset cycle is dropped.

Configuration
REQ-029 Macro ADDSUB_DATAPATH_SAT_EN: when defined, result saturates unsigned (add with carry -> 127, sub with borrow -> 0), carry/ovf still reflect the unsaturated operation and acc uses the saturated result; when undefined, result wraps per REQ-020.

Verification
REQ-030 Wrap mode: A=72,B=122,OP=0 -> 2 cycles later result=66, carry=1, ovf=0, zero=0, out_valid=1.
REQ-031 Sequence 72+122, 57+6, 2-2 back-to-back -> results 66,63,0; zero=1 on third; acc=129; op_count 1,2,0; done=1 one cycle after third result.
REQ-032 A=63,B=1,OP=0 -> result=64, ovf=1, ovf_seen=1 and stays 1 until clr.
REQ-033 A=5,B=9,OP=1 -> result=124, carry=1; with ADDSUB_DATAPATH_SAT_EN result=0; first op of REQ-031 gives 127 and acc=190.
REQ-034 clr asserted same cycle as a result -> acc=0, op_count=0, ovf_seen=0, no done; next result accumulates from 0.
REQ-035 reset asserted with two ops in flight -> no out_valid afterwards, all outputs 0.
